// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and feeds decode
// through an output register plus a 1-entry skid buffer. Optional macro: PC_ALIGN_CHECK_EN.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef PC_ALIGN_CHECK_EN
    ,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jpc,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
`ifdef PC_ALIGN_CHECK_EN
    output logic        addr_err,
`endif
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pending_kill;
    logic [31:0] r_kill_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pcplus4;
`ifdef PC_ALIGN_CHECK_EN
    logic        r_addr_err;
`endif

    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_redirect;
    logic        w_fetching;
    logic        w_out_ready;
    logic        w_skid_load;

    always_comb begin
        w_target_raw = branch_target;
        case (redirect_sel)
            2'b01:   w_target_raw = jpc;
            2'b10:   w_target_raw = jr_target;
            default: w_target_raw = branch_target;
        endcase
    end

    assign w_misaligned = (w_target_raw[1:0] != 2'b00);
`ifdef PC_ALIGN_CHECK_EN
    assign w_target = w_misaligned ? EXC_PC : w_target_raw;
`else
    assign w_target = w_target_raw & 32'hFFFF_FFFC;
`endif

    assign w_redirect  = redirect_en & ~stall & (redirect_sel != 2'b11);
    assign w_fetching  = (r_state == S_FETCH);
    assign w_out_ready = ~r_if_valid | ~stall;
    assign w_skid_load = ~rst & ~w_redirect & w_fetching & imem_ack
                         & ~r_pending_kill & ~w_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_PC;
            r_pending_kill <= 1'b0;
            r_kill_pc      <= 32'h0;
            r_if_valid     <= 1'b0;
            r_if_instr     <= 32'h0;
            r_if_pc        <= 32'h0;
            r_if_pcplus4   <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
            r_addr_err     <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            r_addr_err <= w_redirect & w_misaligned;
`endif
            if (w_redirect) begin
                r_if_valid <= 1'b0;
                r_state    <= S_FETCH;
                // An unacked request must keep its address; the target waits for the kill ack.
                if (w_fetching && !imem_ack) begin
                    r_pending_kill <= 1'b1;
                    r_kill_pc      <= w_target;
                end else begin
                    r_pending_kill <= 1'b0;
                    r_pc           <= w_target;
                end
            end else begin
                if (!stall) begin
                    r_if_valid <= 1'b0;
                end
                if (r_state == S_HOLD) begin
                    if (!stall) begin
                        r_if_valid   <= 1'b1;
                        r_if_instr   <= r_skid_instr;
                        r_if_pc      <= r_skid_pc;
                        r_if_pcplus4 <= r_skid_pc + 32'd4;
                        r_state      <= S_FETCH;
                    end
                end else if (imem_ack) begin
                    if (r_pending_kill) begin
                        r_pending_kill <= 1'b0;
                        r_pc           <= r_kill_pc;
                    end else begin
                        r_pc <= r_pc + 32'd4;
                        if (w_out_ready) begin
                            r_if_valid   <= 1'b1;
                            r_if_instr   <= imem_rdata;
                            r_if_pc      <= r_pc;
                            r_if_pcplus4 <= r_pc + 32'd4;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
            end
        end
    end

    // NOTE: skid data needs no reset; the HOLD state alone marks it as holding a live word.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_instr <= imem_rdata;
            r_skid_pc    <= r_pc;
        end
    end

    assign imem_req   = ~rst & w_fetching;
    assign imem_addr  = r_pc;
    assign if_valid   = r_if_valid;
    assign if_instr   = r_if_instr;
    assign if_pc      = r_if_pc;
    assign if_pcplus4 = r_if_pcplus4;
`ifdef PC_ALIGN_CHECK_EN
    assign addr_err   = r_addr_err;
`endif

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Fetch stage of the 32-bit MIPS core. Owns the program counter and issues instruction-memory requests over a req/ack handshake. Presents {instr, pc, pc+4} to decode through an output register backed by a 1-entry skid buffer. Applies control-transfer redirects resolved in decode; if_pcplus4 feeds the jump-target unit, whose jpc result returns here as a redirect source.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
EXC_PC, 32'h0000_4180, vector for misaligned targets (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  decode cannot accept; hold outputs
redirect_en  in  1  decode resolved a taken branch/jump this cycle
redirect_sel  in  2  00 branch_target, 01 jpc, 10 jr_target, 11 reserved (no redirect)
branch_target  in  32  branch destination
jpc  in  32  jump destination {pc+4[31:28], imm26, 2'b00}
jr_target  in  32  register-indirect destination
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
if_valid  out  1  output register holds a live instruction
if_instr  out  32  instruction
if_pc  out  32  its address
if_pcplus4  out  32  if_pc + 4, mod 2^32

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; state FETCH; if_valid=0, if_instr=0, if_pc=0, if_pcplus4=0; skid empty; pending_kill=0. imem_req=0 while rst=1. imem_addr=pc at all times.
- States: FETCH (imem_req=1), HOLD (imem_req=0, skid full).
- Single outstanding request. imem_addr stays stable from req until ack.
- Output register accepts a word when if_valid=0 or stall=0.
- FETCH, ack=1, pending_kill=0, no redirect:
  - If the output register can accept: load if_instr=rdata, if_pc=pc, if_pcplus4=pc+4, if_valid=1; pc=pc+4; stay in FETCH. Back-to-back acks yield one instruction per cycle.
  - Otherwise: load the skid buffer, pc=pc+4, go to HOLD.
- FETCH, ack=0: no change. Wrap: pc 32'hFFFF_FFFC + 4 = 0.
- HOLD with stall=0: skid moves into the output register (if_valid=1), skid cleared, go to FETCH. The request issues the next cycle, so there is one bubble.
- Consume: stall=0, if_valid=1, no new word loaded → if_valid=0 next edge.
- Redirect (redirect_en=1, stall=0, sel≠11), in the same edge:
  - pc=target; if_valid=0; skid cleared; go to FETCH.
  - If a request is outstanding without ack this cycle: pending_kill=1, and pc is loaded with the target after the kill ack.
  - If ack arrives the same cycle: the word is discarded and the next request uses the target.
- redirect_en ignored while stall=1; decode re-presents it.
- pending_kill=1: the next ack's word is dropped, pending_kill=0, pc=target latched. Latency from redirect to first target instruction on if_valid: 2 cycles with a zero-wait memory.
- Redirect wins over skid/output loads. No branch delay slot: the sequential instruction after a taken transfer is flushed.
- rst mid-transaction: the outstanding ack is ignored (pending_kill cleared). Memory must tolerate an abandoned request.

Optional Feature:
PC_ALIGN_CHECK_EN:
- Defined: adds output addr_err (1). A redirect target with target[1:0]≠00 is replaced by EXC_PC. addr_err pulses high for one cycle on that edge and resets to 0.
- Undefined: target[1:0] forced to 00, no addr_err port.

Test Plan:
- Reset then zero-wait acks, stall=0 → imem_addr 3000, 3004, 3008 on consecutive cycles; if_pc follows one cycle later with if_pcplus4=if_pc+4.
- stall=1 for 3 cycles with if_valid=1, ack on 3004 → HOLD, imem_req=0, if_pc stays 3000. On release: if_pc=3004, then req at 3008 after one bubble.
- Redirect sel=01, jpc=0000_3040, while 3008 outstanding without ack → ack word dropped, next imem_addr=3040, if_valid=0 until 3040 returns.
- Redirect sel=10 with stall=1 → ignored. Same redirect with stall=0 → pc=jr_target.
- pc=FFFF_FFFC fetched → next imem_addr=0000_0000.
- With PC_ALIGN_CHECK_EN: jr_target=0000_3002 → imem_addr=0000_4180, addr_err=1 for one cycle. Without it: imem_addr=0000_3000.
